// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : RV32I load/store unit. It sends one word-wide memory request at a
//            time and returns aligned, extended load data or an exception.
// Revision : 1.0 - initial release
// ============================================================================
module lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        out_valid,
    output logic        out_we,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data,
    output logic        out_exc
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [0:0]  r_state;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [4:0]  r_rd;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;
    logic        r_out_valid;
    logic        r_out_we;
    logic        r_out_exc;
    logic [4:0]  r_out_rd;
    logic [31:0] r_out_data;

    logic        w_legal;
    logic        w_misaligned;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    // Decode the offered operation; funct3[1:0] encodes the access size.
    always_comb begin
        w_legal = 1'b0;
        case (in_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !in_is_store;
            default:                w_legal = 1'b0;
        endcase
        w_misaligned = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                       ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
        case (in_funct3[1:0])
            2'b00: begin
                w_wdata = {4{in_wdata[7:0]}};
                w_wstrb = 4'b0001 << in_addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{in_wdata[15:0]}};
                w_wstrb = 4'b0011 << in_addr[1:0];
            end
            default: begin
                w_wdata = in_wdata;
                w_wstrb = 4'b1111;
            end
        endcase
        if (!in_is_store) begin
            w_wstrb = 4'b0000;
        end
    end

    // Lane selection and extension of returning load data.
    always_comb begin
        w_byte = mem_rdata[{r_off, 3'b000} +: 8];
        w_half = mem_rdata[{r_off[1], 4'b0000} +: 16];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            r_rd        <= 5'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_wstrb <= 4'd0;
            r_out_valid <= 1'b0;
            r_out_we    <= 1'b0;
            r_out_exc   <= 1'b0;
            r_out_rd    <= 5'd0;
            r_out_data  <= 32'd0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_we    <= 1'b0;
            r_out_exc   <= 1'b0;
            if (r_state == S_IDLE) begin
                if (in_valid) begin
                    if (w_legal && !w_misaligned) begin
                        r_state     <= S_REQ;
                        r_funct3    <= in_funct3;
                        r_off       <= in_addr[1:0];
                        r_rd        <= in_rd;
                        r_mem_we    <= in_is_store;
                        r_mem_addr  <= {in_addr[31:2], 2'b00};
                        r_mem_wdata <= w_wdata;
                        r_mem_wstrb <= w_wstrb;
                    end else begin
                        // Faulting access never reaches memory.
                        r_out_valid <= 1'b1;
                        r_out_exc   <= 1'b1;
                        r_out_rd    <= in_rd;
                        r_out_data  <= in_addr;
                    end
                end
            end else if (mem_ack) begin
                r_state     <= S_IDLE;
                r_out_valid <= 1'b1;
                r_out_we    <= !r_mem_we && (r_rd != 5'd0);
                r_out_rd    <= r_rd;
                r_out_data  <= r_mem_we ? 32'd0 : w_load_data;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign mem_req   = (r_state == S_REQ);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign out_valid = r_out_valid;
    assign out_we    = r_out_we;
    assign out_rd    = r_out_rd;
    assign out_data  = r_out_data;
    assign out_exc   = r_out_exc;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Directed and random checks of lsu against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        out_valid;
    logic        out_we;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_exc;

    int total = 0;
    int bad   = 0;

    lsu dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .out_valid(out_valid), .out_we(out_we), .out_rd(out_rd),
        .out_data(out_data), .out_exc(out_exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: access size in bytes, 0 when the funct3 is illegal.
    function automatic int size_of(input logic st, input logic [2:0] f3);
        case (f3)
            3'd0: return 1;
            3'd1: return 2;
            3'd2: return 4;
            3'd4: return st ? 0 : 1;
            3'd5: return st ? 0 : 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
        int sz = size_of(1'b0, f3);
        logic [31:0] v = rdata >> (8 * (a % 4));
        if (sz == 4) return rdata;
        v = v % (32'd1 << (8 * sz));
        if (f3 < 3'd4 && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
        return v;
    endfunction

    task automatic idle();
        in_valid = 1'b0;
        tick();
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_mem_req", 32'(mem_req), 32'd0);
    endtask

    // Offer one op at the current cycle and follow it to completion.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] rdata, input int waits);
        int sz;
        logic [31:0] ewd;
        logic [3:0]  estrb;
        sz = size_of(st, f3);
        in_valid = 1'b1; in_is_store = st; in_funct3 = f3;
        in_addr = a; in_wdata = wd; in_rd = rd;
        tick();
        if (sz == 0 || (a % sz) != 0) begin
            check("exc_valid", 32'(out_valid), 32'd1);
            check("exc_flag", 32'(out_exc), 32'd1);
            check("exc_data", out_data, a);
            check("exc_we", 32'(out_we), 32'd0);
            check("exc_rd", 32'(out_rd), 32'(rd));
            check("exc_busy", 32'(busy), 32'd0);
            check("exc_mem_req", 32'(mem_req), 32'd0);
            return;
        end
        ewd   = (sz == 1) ? wd[7:0] * 32'h0101_0101 :
                (sz == 2) ? wd[15:0] * 32'h0001_0001 : wd;
        estrb = !st ? 4'd0 : 4'(((1 << sz) - 1) << (a % 4));
        for (int w = 0; w <= waits; w++) begin
            check("req_mem_req", 32'(mem_req), 32'd1);
            check("req_busy", 32'(busy), 32'd1);
            check("req_out_valid", 32'(out_valid), 32'd0);
            check("req_addr", mem_addr, a - (a % 4));
            check("req_we", 32'(mem_we), 32'(st));
            check("req_wstrb", 32'(mem_wstrb), 32'(estrb));
            if (st) check("req_wdata", mem_wdata, ewd);
            mem_ack   = (w == waits);
            mem_rdata = (w == waits) ? rdata : $urandom;
            tick();
        end
        mem_ack = 1'b0;
        check("done_valid", 32'(out_valid), 32'd1);
        check("done_exc", 32'(out_exc), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("done_rd", 32'(out_rd), 32'(rd));
        check("done_we", 32'(out_we), 32'(!st && rd != 5'd0));
        check("done_data", out_data, st ? 32'd0 : ref_load(f3, a, rdata));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_is_store = 1'b0; in_funct3 = 3'd0;
        in_addr = 32'd0; in_wdata = 32'd0; in_rd = 5'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_exc", 32'(out_exc), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_wstrb", 32'(mem_wstrb), 32'd0);
        idle();

        // Directed cases.
        run_op(1'b0, 3'b010, 32'h0000_1000, 32'd0, 5'd5, 32'hDEAD_BEEF, 0);
        check("lw_value", out_data, 32'hDEAD_BEEF);
        run_op(1'b0, 3'b000, 32'h0000_1003, 32'd0, 5'd6, 32'h80AB_CDEF, 0);
        check("lb_value", out_data, 32'hFFFF_FF80);
        run_op(1'b0, 3'b100, 32'h0000_1003, 32'd0, 5'd6, 32'h80AB_CDEF, 0);
        check("lbu_value", out_data, 32'h0000_0080);
        run_op(1'b0, 3'b101, 32'h0000_1002, 32'd0, 5'd7, 32'h8001_1234, 0);
        check("lhu_value", out_data, 32'h0000_8001);
        in_valid = 1'b0; tick();
        run_op(1'b1, 3'b000, 32'h0000_2001, 32'h1234_56A5, 5'd1, 32'd0, 0);
        run_op(1'b1, 3'b001, 32'h0000_2002, 32'h1234_56A5, 5'd1, 32'd0, 1);
        idle();
        run_op(1'b0, 3'b010, 32'h0000_1001, 32'd0, 5'd3, 32'd0, 0);
        idle();
        run_op(1'b0, 3'b011, 32'h0000_1000, 32'd0, 5'd3, 32'd0, 0);
        idle();
        run_op(1'b1, 3'b001, 32'h0000_3003, 32'd0, 5'd3, 32'd0, 0);
        idle();
        // Stalled load to x0, followed immediately by a second op.
        run_op(1'b0, 3'b010, 32'h0000_5000, 32'd0, 5'd0, 32'h1111_2222, 3);
        run_op(1'b0, 3'b001, 32'h0000_5002, 32'd0, 5'd9, 32'hF00D_0000, 0);
        check("lh_value", out_data, 32'hFFFF_F00D);
        idle();

        // Reset during an outstanding request; the late ack must be ignored.
        in_valid = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b010;
        in_addr = 32'h0000_4000; in_rd = 5'd4;
        tick();
        in_valid = 1'b0;
        tick();
        check("rst_req_pending", 32'(mem_req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_abort_req", 32'(mem_req), 32'd0);
        check("rst_abort_busy", 32'(busy), 32'd0);
        check("rst_abort_valid", 32'(out_valid), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        check("late_ack_valid", 32'(out_valid), 32'd0);
        check("late_ack_busy", 32'(busy), 32'd0);
        idle();

        // Random operations with random wait states.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
                   5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
